// File: rtl/idma_pkg.sv
// Shared types and field positions for the transfer scheduler: FSM states,
// command word C1 layout, status word layout and AXI response codes.
package idma_pkg;

    typedef enum logic [2:0] {
        ST_RST,
        ST_IDLE,
        ST_CALC,
        ST_C1,
        ST_C2,
        ST_C3,
        ST_WAIT,
        ST_DONE
    } state_e;

    // C1 word: {dir, 3'b000, bytes[11:0], local addr[15:0]}
    localparam int C1_DIR      = 31;
    localparam int C1_BYTES_HI = 27;
    localparam int C1_BYTES_LO = 16;
    localparam int C1_ADDR_HI  = 15;
    localparam int C1_ADDR_LO  = 0;

    // Status word shares dir/bytes/addr positions with C1, adds resp
    localparam int ST_DIR      = 31;
    localparam int ST_RESP_HI  = 29;
    localparam int ST_RESP_LO  = 28;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic [31:0] c1_word(input logic dir, input logic [11:0] bytes,
                                            input logic [15:0] addr);
        return {dir, 3'b000, bytes, addr};
    endfunction

endpackage

// File: rtl/idma_chunk_calc.sv
// Chunk size: the smaller of the bytes left and the distance to the next
// MAX_BYTES-aligned external boundary.
module idma_chunk_calc #(
    parameter int MAX_BYTES = 256
) (
    input  logic [15:0] i_remaining,
    input  logic [10:0] i_ext_addr,
    output logic [11:0] o_chunk
);

    logic [11:0] w_off;
    logic [11:0] w_room;

    assign w_off   = {1'b0, i_ext_addr} & 12'(MAX_BYTES - 1);
    assign w_room  = 12'(MAX_BYTES) - w_off;
    assign o_chunk = (i_remaining < {4'd0, w_room}) ? i_remaining[11:0] : w_room;

endmodule

// File: rtl/idma_cmd_sched.sv
// Splits one copy request into boundary-safe chunks, issues a 3-word command
// per chunk to the mover, checks each status and reports one completion.
module idma_cmd_sched
    import idma_pkg::*;
#(
    parameter int MAX_BYTES = 256
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_dir,
    input  logic [15:0] req_bytes,
    input  logic [15:0] req_int_addr,
    input  logic [63:0] req_ext_addr,
    output logic [31:0] cmd_m_tdata,
    output logic        cmd_m_tvalid,
    output logic        cmd_m_tlast,
    input  logic        cmd_m_tready,
    input  logic [31:0] stat_s_tdata,
    input  logic        stat_s_tvalid,
    input  logic        stat_s_tlast,
    output logic        stat_s_tready,
    output logic        done_valid,
    input  logic        done_ready,
    output logic        done_error,
    output logic [15:0] done_bytes
);

    state_e      r_state;
    state_e      w_next;
    logic        r_dir;
    logic        r_err;
    logic [15:0] r_rem;
    logic [15:0] r_int;
    logic [15:0] r_acc;
    logic [63:0] r_ext;
    logic [11:0] r_chunk;
    logic [11:0] w_chunk;
    logic [15:0] w_rem_next;
    logic        w_mismatch;
    logic        w_bad;
    logic        w_unused_stat;

    idma_chunk_calc #(.MAX_BYTES(MAX_BYTES)) u_chunk_calc (
        .i_remaining (r_rem),
        .i_ext_addr  (r_ext[10:0]),
        .o_chunk     (w_chunk)
    );

    // tlast and the reserved status bit carry no information here
    assign w_unused_stat = ^{stat_s_tlast, stat_s_tdata[30]};

    assign w_mismatch = (stat_s_tdata[ST_DIR] != r_dir)
                     || (stat_s_tdata[C1_BYTES_HI:C1_BYTES_LO] != r_chunk)
                     || (stat_s_tdata[C1_ADDR_HI:C1_ADDR_LO] != r_int);
    assign w_bad      = (stat_s_tdata[ST_RESP_HI:ST_RESP_LO] != RESP_OKAY) || w_mismatch;
    assign w_rem_next = r_rem - {4'd0, r_chunk};

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RST:  w_next = ST_IDLE;
            ST_IDLE: if (req_valid) w_next = (req_bytes == 16'd0) ? ST_DONE : ST_CALC;
            ST_CALC: w_next = ST_C1;
            ST_C1:   if (cmd_m_tready) w_next = ST_C2;
            ST_C2:   if (cmd_m_tready) w_next = ST_C3;
            ST_C3:   if (cmd_m_tready) w_next = ST_WAIT;
            ST_WAIT: if (stat_s_tvalid)
                         w_next = (r_err || w_bad || w_rem_next == 16'd0) ? ST_DONE : ST_CALC;
            ST_DONE: if (done_ready) w_next = ST_IDLE;
            default: w_next = ST_RST;
        endcase
    end

    always_comb begin
        req_ready     = 1'b0;
        cmd_m_tvalid  = 1'b0;
        cmd_m_tlast   = 1'b0;
        cmd_m_tdata   = 32'd0;
        stat_s_tready = 1'b0;
        done_valid    = 1'b0;
        done_error    = 1'b0;
        done_bytes    = 16'd0;
        case (r_state)
            ST_IDLE: req_ready = 1'b1;
            ST_C1: begin
                cmd_m_tvalid = 1'b1;
                cmd_m_tdata  = c1_word(r_dir, r_chunk, r_int);
            end
            ST_C2: begin
                cmd_m_tvalid = 1'b1;
                cmd_m_tdata  = r_ext[31:0];
            end
            ST_C3: begin
                cmd_m_tvalid = 1'b1;
                cmd_m_tlast  = 1'b1;
                cmd_m_tdata  = r_ext[63:32];
            end
            ST_WAIT: stat_s_tready = 1'b1;
            ST_DONE: begin
                done_valid = 1'b1;
                done_error = r_err;
                done_bytes = r_acc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= ST_RST;
            r_dir   <= 1'b0;
            r_err   <= 1'b0;
            r_rem   <= 16'd0;
            r_int   <= 16'd0;
            r_acc   <= 16'd0;
            r_ext   <= 64'd0;
            r_chunk <= 12'd0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && req_valid) begin
                r_dir <= req_dir;
                r_rem <= req_bytes;
                r_int <= req_int_addr;
                r_ext <= req_ext_addr;
                r_err <= 1'b0;
                r_acc <= 16'd0;
            end
            if (r_state == ST_CALC) r_chunk <= w_chunk;
            // Addresses advance even on a failed chunk; the transfer stops anyway
            if (r_state == ST_WAIT && stat_s_tvalid) begin
                if (w_bad) r_err <= 1'b1;
                else       r_acc <= r_acc + {4'd0, r_chunk};
                r_int <= r_int + {4'd0, r_chunk};
                r_ext <= r_ext + {52'd0, r_chunk};
                r_rem <= w_rem_next;
            end
        end
    end

endmodule

// File: tb/tb_idma_cmd_sched.sv
// Randomized bench: acts as the mover, predicts every command word, status
// outcome and completion from the chunking rule computed with plain arithmetic.
module tb_idma_cmd_sched;

    localparam int MAX    = 256;
    localparam int BUDGET = 300;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_dir = 1'b0;
    logic [15:0] req_bytes = 16'd0;
    logic [15:0] req_int_addr = 16'd0;
    logic [63:0] req_ext_addr = 64'd0;
    logic [31:0] cmd_m_tdata;
    logic        cmd_m_tvalid;
    logic        cmd_m_tlast;
    logic        cmd_m_tready = 1'b0;
    logic [31:0] stat_s_tdata = 32'd0;
    logic        stat_s_tvalid = 1'b0;
    logic        stat_s_tlast = 1'b0;
    logic        stat_s_tready;
    logic        done_valid;
    logic        done_ready = 1'b0;
    logic        done_error;
    logic [15:0] done_bytes;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    idma_cmd_sched #(.MAX_BYTES(MAX)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dir       (req_dir),
        .req_bytes     (req_bytes),
        .req_int_addr  (req_int_addr),
        .req_ext_addr  (req_ext_addr),
        .cmd_m_tdata   (cmd_m_tdata),
        .cmd_m_tvalid  (cmd_m_tvalid),
        .cmd_m_tlast   (cmd_m_tlast),
        .cmd_m_tready  (cmd_m_tready),
        .stat_s_tdata  (stat_s_tdata),
        .stat_s_tvalid (stat_s_tvalid),
        .stat_s_tlast  (stat_s_tlast),
        .stat_s_tready (stat_s_tready),
        .done_valid    (done_valid),
        .done_ready    (done_ready),
        .done_error    (done_error),
        .done_bytes    (done_bytes)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_req(input logic dir, input logic [15:0] bytes, input logic [15:0] ia,
                            input logic [63:0] ea, output int acc_c);
        int n = 0;
        bit got = 0;
        acc_c = cyc;
        @(negedge aclk);
        req_valid = 1'b1; req_dir = dir; req_bytes = bytes;
        req_int_addr = ia; req_ext_addr = ea;
        while (!got && n < BUDGET) begin
            #1;
            if (req_ready) begin
                acc_c = cyc; got = 1;
                @(posedge aclk); #1;
            end else begin
                @(negedge aclk); n++;
            end
        end
        req_valid = 1'b0;
        chk("req_accept", 64'(got), 64'(1));
    endtask

    task automatic get_cmd(input bit stall, output logic [31:0] w, output logic l,
                           output int first_c);
        logic [31:0] held = 32'd0;
        bit have = 0;
        bit got = 0;
        int n = 0;
        first_c = -1; w = 32'd0; l = 1'b0;
        while (!got && n < BUDGET) begin
            @(negedge aclk);
            cmd_m_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            chk("stat_rdy_low", 64'(stat_s_tready), 64'(0));
            if (cmd_m_tvalid) begin
                if (first_c < 0) first_c = cyc;
                if (have) chk("tdata_stable", 64'(cmd_m_tdata), 64'(held));
                if (cmd_m_tready) begin
                    w = cmd_m_tdata; l = cmd_m_tlast; got = 1;
                    @(posedge aclk); #1;
                    cmd_m_tready = 1'b0;
                end else begin
                    held = cmd_m_tdata; have = 1;
                end
            end
            n++;
        end
        chk("cmd_hs", 64'(got), 64'(1));
    endtask

    task automatic send_stat(input logic [31:0] st, input bit stall, output int sc);
        int n = 0;
        bit got = 0;
        sc = cyc;
        if (stall) repeat ($urandom_range(0, 2)) @(negedge aclk);
        while (!got && n < BUDGET) begin
            @(negedge aclk);
            stat_s_tvalid = 1'b1; stat_s_tdata = st;
            stat_s_tlast = 1'($urandom_range(0, 1));
            #1;
            if (stat_s_tready) begin
                sc = cyc; got = 1;
                @(posedge aclk); #1;
            end
            n++;
        end
        stat_s_tvalid = 1'b0;
        chk("stat_hs", 64'(got), 64'(1));
    endtask

    task automatic wait_done(input logic e_err, input logic [15:0] e_bytes, input int rc);
        int n = 0;
        int first = -1;
        bit got = 0;
        while (!got && n < BUDGET) begin
            @(negedge aclk);
            done_ready = 1'($urandom_range(0, 1));
            #1;
            chk("no_cmd_in_done", 64'(cmd_m_tvalid), 64'(0));
            if (done_valid) begin
                if (first < 0) begin
                    first = cyc;
                    chk("done_lat", 64'(first - rc), 64'(1));
                end
                if (done_ready) begin
                    chk("done_error", 64'(done_error), 64'(e_err));
                    chk("done_bytes", 64'(done_bytes), 64'(e_bytes));
                    got = 1;
                    @(posedge aclk); #1;
                end
            end
            n++;
        end
        done_ready = 1'b0;
        chk("done_hs", 64'(got), 64'(1));
    endtask

    // fkind: 1 resp SLVERR, 2 bytes off by one, 3 dir flipped, 4 addr off by one
    task automatic run_req(input logic dir, input logic [15:0] bytes, input logic [15:0] ia0,
                           input logic [63:0] ea0, input int fidx, input int fkind,
                           input bit stall, input bit early);
        int rem = int'(bytes);
        logic [15:0] ia = ia0;
        logic [63:0] ea = ea0;
        logic [15:0] accm = 16'd0;
        bit errm = 0;
        int idx = 0;
        int refc, fc, c;
        logic [31:0] w, st;
        logic l;
        logic [11:0] c12;
        send_req(dir, bytes, ia0, ea0, refc);
        while (rem > 0 && !errm) begin
            c = MAX - int'(ea % 64'(MAX));
            if (rem < c) c = rem;
            c12 = 12'(c);
            st = {dir, 1'b0, 2'b00, c12, ia};
            if (idx == fidx) begin
                case (fkind)
                    1: st[29:28] = 2'b10;
                    2: st[27:16] = c12 + 12'd1;
                    3: st[31]    = ~dir;
                    default: st[15:0] = ia + 16'd1;
                endcase
                errm = 1;
            end
            if (early && idx == fidx) begin
                stat_s_tvalid = 1'b1; stat_s_tdata = st;
            end
            get_cmd(stall, w, l, fc);
            chk("c1_word", 64'(w), 64'({dir, 3'b000, c12, ia}));
            chk("c1_last", 64'(l), 64'(0));
            chk("c1_lat", 64'(fc - refc), 64'(2));
            get_cmd(stall, w, l, fc);
            chk("c2_word", 64'(w), 64'(ea[31:0]));
            chk("c2_last", 64'(l), 64'(0));
            get_cmd(stall, w, l, fc);
            chk("c3_word", 64'(w), 64'(ea[63:32]));
            chk("c3_last", 64'(l), 64'(1));
            send_stat(st, stall && !early, refc);
            if (!errm) accm = accm + 16'(c);
            ia = ia + 16'(c);
            ea = ea + 64'(c);
            rem = rem - c;
            idx++;
        end
        wait_done(errm, accm, refc);
    endtask

    initial begin
        int rc, fc, fidx, fkind;
        logic [31:0] w;
        logic l;
        logic [15:0] b;
        logic [63:0] e;

        repeat (3) @(posedge aclk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_cmd_tvalid", 64'(cmd_m_tvalid), 64'(0));
        chk("rst_cmd_tlast", 64'(cmd_m_tlast), 64'(0));
        chk("rst_cmd_tdata", 64'(cmd_m_tdata), 64'(0));
        chk("rst_stat_tready", 64'(stat_s_tready), 64'(0));
        chk("rst_done_valid", 64'(done_valid), 64'(0));
        chk("rst_done_error", 64'(done_error), 64'(0));
        chk("rst_done_bytes", 64'(done_bytes), 64'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("rdy_before_edge", 64'(req_ready), 64'(0));
        @(posedge aclk); #1;
        chk("rdy_after_rst", 64'(req_ready), 64'(1));

        run_req(1'b1, 16'd600, 16'h0040, 64'h0000_0000_1000_00F0, -1, 0, 0, 0);
        run_req(1'b0, 16'd0, 16'h1234, 64'h0000_0000_0000_0010, -1, 0, 0, 0);
        run_req(1'b0, 16'd512, 16'h0100, 64'h0, 0, 1, 0, 0);
        run_req(1'b1, 16'd1000, 16'h0FF0, 64'h0000_0001_0000_0080, -1, 0, 1, 0);
        run_req(1'b0, 16'd300, 16'h0200, 64'h0000_0000_0000_0040, 0, 2, 0, 1);
        run_req(1'b1, 16'd700, 16'hFFC0, 64'h0000_0000_FFFF_FF80, -1, 0, 0, 0);

        // reset while C2 is on the bus
        send_req(1'b1, 16'd512, 16'h0000, 64'h0, rc);
        get_cmd(1'b0, w, l, fc);
        @(negedge aclk);
        cmd_m_tready = 1'b0;
        #1;
        chk("mid_in_c2", 64'(cmd_m_tvalid), 64'(1));
        aresetn = 1'b0;
        @(posedge aclk); #1;
        chk("mid_rst_tvalid", 64'(cmd_m_tvalid), 64'(0));
        chk("mid_rst_ready", 64'(req_ready), 64'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("mid_rel_ready", 64'(req_ready), 64'(1));
        run_req(1'b0, 16'd260, 16'h0010, 64'h0000_0000_0000_00FC, -1, 0, 0, 0);

        for (int k = 0; k < 25; k++) begin
            b = (k % 5 == 0) ? 16'($urandom_range(0, 8)) : 16'($urandom_range(1, 3000));
            e = {32'($urandom), 32'($urandom)};
            if (k % 3 == 0) e[31:0] = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            fidx  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
            fkind = int'($urandom_range(1, 4));
            run_req(1'($urandom_range(0, 1)), b, 16'($urandom), e, fidx, fkind,
                    1'($urandom_range(0, 1)), 1'b0);
        end
        run_req(1'b1, 16'hFFFF, 16'h0001, 64'h0000_0000_0000_0003, -1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
